pe_namespace_ctrl: RTL and testbench
====================================

Name: pe_namespace_ctrl

Overview:
- Parametrised next-generation PE namespace controller. It sits between the PU memory lanes and one PE core.
- Owns the data, weight and meta scratchpads. Steers lane writes into them by namespace type and tracks data readiness with a fill counter.
- Arbitrates weight writes between memory and core using a one-entry skid buffer.
- Adds a flow-controlled weight readback stream back to memory.

Parameters:
- peId, 1, global PE index.
- numPe, 8, PEs per PU; PEs with peId%numPe==0 build no RAMs.
- peIdLen, 6, bit width of the PE index space.
- numLanes, 4, memory lanes per PU group; must be a power of 2.
- logNumLanes, 2, log2(numLanes).
- dataLen, 16, word width of all namespaces.
- dataAddrLen, 5, data namespace depth = 2^dataAddrLen.
- weightAddrLen, 5, weight namespace depth = 2^weightAddrLen.
- metaAddrLen, 2, meta namespace depth = 2^metaAddrLen.

Ports:
- clk, in, 1, clock.
- reset, in, 1, synchronous active-high reset.
- eoc, in, 1, end of computation; clears all write counters.
- mem_wrt_valid, in, 1, lane write strobe.
- mem_lane_id, in, logNumLanes, target lane of the write.
- mem_data_type, in, 2, namespace code (pe_ns_pkg).
- mem_data_input, in, dataLen, write data.
- mem_rdbk_req, in, 1, pulse that starts a weight readback.
- mem_rdbk_ready, in, 1, memory accepts a readback word.
- mem_rdbk_valid, out, 1, readback word valid.
- mem_rdbk_last, out, 1, final readback word.
- mem_data_output, out, dataLen, readback word.
- core_data_rd_addr, in, dataAddrLen, core data read address.
- data_out, out, dataLen, data read result.
- data_out_v, out, 1, data_out holds a written entry.
- core_weight_wrt, in, 1, core weight write.
- core_weight_wrt_addr, in, weightAddrLen, core weight write address.
- core_weight_wrt_data, in, dataLen, core weight write data.
- core_weight_stall, out, 1, core must hold its weight access.
- core_weight_rd_addr, in, weightAddrLen, core weight read address.
- weight_out, out, dataLen, weight read result.
- core_meta_rd_addr, in, metaAddrLen, core meta read address.
- meta_out, out, dataLen, meta read result.

Behaviour:
- Clocking: single clk. Reset is synchronous and active-high, with the ports named clk and reset.
- Reset: all outputs are 0, all counters are 0, the skid buffer is empty and the FSM is in IDLE.
- Lane hit: hit = mem_wrt_valid && mem_lane_id == peId[peIdLen-1 -: logNumLanes].
- Namespace writes: on a hit, the word goes to the namespace selected by mem_data_type at that namespace's write counter, which then increments by 1. INST words are ignored.
- Counter widths: each counter is addrLen+1 bits and saturates at depth. A write while the counter equals depth goes to addr 0 and wraps the counter to 1.
- eoc: all write counters return to 0 on the next edge. If eoc and a hit occur in the same cycle, eoc wins and the write is dropped.
- Read latency: data, weight and meta reads take 1 cycle from address to output.
- data_out_v: registered as (core_data_rd_addr < data_wr_cnt) and aligned with data_out.
- Weight arbitration:
  - A memory weight write (hit with type WEIGHT) has priority.
  - A colliding core write is captured in the skid buffer and retired on the next free cycle.
  - core_weight_stall is asserted combinationally while the skid buffer is full and another core write collides, or while the FSM is not IDLE.
  - A stalled write is not accepted.
- Readback FSM:
  - IDLE: on mem_rdbk_req, go to ISSUE with rdbk_addr = 0.
  - ISSUE: the weight RAM read port takes rdbk_addr, overriding core_weight_rd_addr; go to HOLD.
  - HOLD: mem_rdbk_valid = 1 and mem_data_output holds the registered RAM word. mem_rdbk_last = 1 when rdbk_addr == depth-1.
  - HOLD with mem_rdbk_ready: if last, go to IDLE; otherwise rdbk_addr + 1 and go to ISSUE.
  - Throughput is one word per 2 cycles.
  - mem_rdbk_req outside IDLE is ignored.
  - eoc does not abort a readback; only reset does.
- No-namespace PE: when peId%numPe==0, no RAMs are built. data_out, weight_out, meta_out and data_out_v are tied to 0. The readback completes with data 0.

Optional Feature:
- Macro: PE_NS_OVF_CHECK_EN.
- With the macro defined: output ns_ovf_err (1 bit) is added. It is a sticky flag set on any hit that arrives while the target counter equals depth. That write is dropped and the counter is held. The flag clears on reset only.
- Without the macro: no port is added, and the wrap behaviour in Behaviour applies.

Decomposition:
- Package pe_ns_pkg:
  - namespace codes NS_INST=2'd0, NS_DATA=2'd1, NS_WEIGHT=2'd2, NS_META=2'd3;
  - readback FSM state encoding IDLE/ISSUE/HOLD.
- Sub-module pe_ns_ram: simple dual-port RAM with one write port, one read port and a registered 1-cycle read, parametrised in width and depth. It is instantiated three times.

Test Plan:
- Data readiness: a lane-hit DATA write of 0x1111, 0x2222, 0x3333 then reading addr 2 -> data_out=0x3333 with data_out_v=1 one cycle later. Reading addr 3 -> data_out_v=0.
- Lane filtering: peId=9, peIdLen=6. A write on lane 1 is ignored. A write on lane 0 lands at data addr 0 (peId[5:4]=0).
- Weight collision: a memory weight write to addr 4 (0xAAAA) and a core write to addr 5 (0xBBBB) in the same cycle -> both stored, core_weight_stall=0. A second collision the next cycle -> stall=1 for 1 cycle.
- Readback: 32 weights are loaded, then mem_rdbk_req is pulsed with ready toggling -> 32 words arrive in address order, last asserted on word 31, FSM back in IDLE.
- eoc: eoc with a simultaneous DATA hit -> the write is dropped, data_wr_cnt=0, data_out_v=0 for addr 0.
- Overflow with the macro defined: 33 DATA writes with dataAddrLen=5 -> ns_ovf_err=1, addr 0 unchanged. Without the macro -> addr 0 is overwritten.

Source files
------------

// File: rtl/pe_ns_pkg.sv
// Shared namespace codes and readback FSM encoding for the PE namespace controller.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package pe_ns_pkg;

    // Namespace code carried on mem_data_type.
    typedef enum logic [1:0] {
        NS_INST   = 2'd0,
        NS_DATA   = 2'd1,
        NS_WEIGHT = 2'd2,
        NS_META   = 2'd3
    } ns_type_e;

    // Weight readback FSM.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } rdbk_state_e;

endpackage

// File: rtl/pe_ns_ram.sv
// Simple dual-port scratchpad: one write port, one registered read port.
// Latency: read data appears 1 cycle after raddr; read-during-write returns old data.
// Backpressure: none, accepts a write and a read every cycle.
// Ports: clk/reset, we/waddr/wdata write port, raddr/rdata read port (rdata clears on reset).
module pe_ns_ram
    import pe_ns_pkg::*;
#(
    parameter int W  = 16,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/pe_namespace_ctrl.sv
// PE namespace controller: steers lane writes into data/weight/meta scratchpads, arbitrates weight writes, streams weights back.
// Latency: core reads 1 cycle; readback delivers one word per 2 cycles (ISSUE then HOLD).
// Backpressure: core_weight_stall holds core weight writes; readback holds a word in HOLD until mem_rdbk_ready.
// Ports: mem_* lane write and readback stream, core_* scratchpad reads and weight writes, eoc clears fill counters.
// Optional: PE_NS_OVF_CHECK_EN adds sticky ns_ovf_err and drops writes into a full namespace instead of wrapping.
module pe_namespace_ctrl
    import pe_ns_pkg::*;
#(
    parameter int peId          = 1,
    parameter int numPe         = 8,
    parameter int peIdLen       = 6,
    parameter int numLanes      = 4,
    parameter int logNumLanes   = 2,
    parameter int dataLen       = 16,
    parameter int dataAddrLen   = 5,
    parameter int weightAddrLen = 5,
    parameter int metaAddrLen   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     eoc,
    input  logic                     mem_wrt_valid,
    input  logic [logNumLanes-1:0]   mem_lane_id,
    input  logic [1:0]               mem_data_type,
    input  logic [dataLen-1:0]       mem_data_input,
    input  logic                     mem_rdbk_req,
    input  logic                     mem_rdbk_ready,
    output logic                     mem_rdbk_valid,
    output logic                     mem_rdbk_last,
    output logic [dataLen-1:0]       mem_data_output,
    input  logic [dataAddrLen-1:0]   core_data_rd_addr,
    output logic [dataLen-1:0]       data_out,
    output logic                     data_out_v,
    input  logic                     core_weight_wrt,
    input  logic [weightAddrLen-1:0] core_weight_wrt_addr,
    input  logic [dataLen-1:0]       core_weight_wrt_data,
    output logic                     core_weight_stall,
    input  logic [weightAddrLen-1:0] core_weight_rd_addr,
    output logic [dataLen-1:0]       weight_out,
    input  logic [metaAddrLen-1:0]   core_meta_rd_addr,
    output logic [dataLen-1:0]       meta_out
`ifdef PE_NS_OVF_CHECK_EN
    ,
    output logic                     ns_ovf_err
`endif
);

    localparam bit NO_NS = (peId % numPe) == 0;
    localparam logic [peIdLen-1:0]     PE_ID_BITS = peIdLen'(peId);
    localparam logic [logNumLanes-1:0] LANE_SEL   = PE_ID_BITS[peIdLen-1 -: logNumLanes];

    localparam logic [dataAddrLen:0]   D_DEPTH = {1'b1, {dataAddrLen{1'b0}}};
    localparam logic [dataAddrLen:0]   D_ONE   = {{dataAddrLen{1'b0}}, 1'b1};
    localparam logic [weightAddrLen:0] W_DEPTH = {1'b1, {weightAddrLen{1'b0}}};
    localparam logic [weightAddrLen:0] W_ONE   = {{weightAddrLen{1'b0}}, 1'b1};
    localparam logic [metaAddrLen:0]   M_DEPTH = {1'b1, {metaAddrLen{1'b0}}};
    localparam logic [metaAddrLen:0]   M_ONE   = {{metaAddrLen{1'b0}}, 1'b1};

    // ---------------- lane hit and fill counters ----------------
    logic hit, data_hit, weight_hit, meta_hit;
    logic data_full, weight_full, meta_full;
    logic data_we, mem_w_we, meta_we;
    logic [dataAddrLen:0]   data_wr_cnt;
    logic [weightAddrLen:0] weight_wr_cnt;
    logic [metaAddrLen:0]   meta_wr_cnt;

    // eoc wins over a same-cycle hit.
    assign hit        = mem_wrt_valid && (mem_lane_id == LANE_SEL) && !eoc;
    assign data_hit   = hit && (mem_data_type == NS_DATA);
    assign weight_hit = hit && (mem_data_type == NS_WEIGHT);
    assign meta_hit   = hit && (mem_data_type == NS_META);

    assign data_full   = (data_wr_cnt == D_DEPTH);
    assign weight_full = (weight_wr_cnt == W_DEPTH);
    assign meta_full   = (meta_wr_cnt == M_DEPTH);

`ifdef PE_NS_OVF_CHECK_EN
    assign data_we  = data_hit && !data_full;
    assign mem_w_we = weight_hit && !weight_full;
    assign meta_we  = meta_hit && !meta_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            ns_ovf_err <= 1'b0;
        end else if ((data_hit && data_full) || (weight_hit && weight_full) ||
                     (meta_hit && meta_full)) begin
            ns_ovf_err <= 1'b1;
        end
    end
`else
    assign data_we  = data_hit;
    assign mem_w_we = weight_hit;
    assign meta_we  = meta_hit;
`endif

    // A full counter's low bits are zero, so the wrap write lands at addr 0 for free.
    always_ff @(posedge clk) begin
        if (reset || eoc) begin
            data_wr_cnt   <= '0;
            weight_wr_cnt <= '0;
            meta_wr_cnt   <= '0;
        end else begin
            if (data_we)  data_wr_cnt   <= data_full   ? D_ONE : data_wr_cnt + 1'b1;
            if (mem_w_we) weight_wr_cnt <= weight_full ? W_ONE : weight_wr_cnt + 1'b1;
            if (meta_we)  meta_wr_cnt   <= meta_full   ? M_ONE : meta_wr_cnt + 1'b1;
        end
    end

    // ---------------- weight write arbitration ----------------
    rdbk_state_e state, state_nxt;
    logic                     skid_vld;
    logic [weightAddrLen-1:0] skid_addr;
    logic [dataLen-1:0]       skid_dat;
    logic                     core_acc;
    logic                     w_we;
    logic [weightAddrLen-1:0] w_waddr;
    logic [dataLen-1:0]       w_wdata;

    assign core_weight_stall = (state != IDLE) || (skid_vld && mem_w_we && core_weight_wrt);
    assign core_acc          = core_weight_wrt && !core_weight_stall;

    // Memory first, then the parked core write, then a fresh core write.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = core_weight_wrt_addr;
        w_wdata = core_weight_wrt_data;
        if (mem_w_we) begin
            w_we    = 1'b1;
            w_waddr = weight_wr_cnt[weightAddrLen-1:0];
            w_wdata = mem_data_input;
        end else if (skid_vld) begin
            w_we    = 1'b1;
            w_waddr = skid_addr;
            w_wdata = skid_dat;
        end else if (core_acc) begin
            w_we    = 1'b1;
        end
    end

    // An accepted core write parks whenever the port is taken this cycle; with the
    // skid full and the port free the old entry retires and the new one parks behind it.
    always_ff @(posedge clk) begin
        if (reset) begin
            skid_vld  <= 1'b0;
            skid_addr <= '0;
            skid_dat  <= '0;
        end else if (core_acc && (mem_w_we || skid_vld)) begin
            skid_vld  <= 1'b1;
            skid_addr <= core_weight_wrt_addr;
            skid_dat  <= core_weight_wrt_data;
        end else if (!mem_w_we && skid_vld) begin
            skid_vld  <= 1'b0;
        end
    end

    // ---------------- readback FSM ----------------
    logic [weightAddrLen-1:0] rdbk_addr, rdbk_addr_nxt;
    logic                     rdbk_sel;
    logic                     hold_new;
    logic [dataLen-1:0]       rdbk_dat;
    logic [dataLen-1:0]       w_q, data_q, meta_q;
    logic                     data_v_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rdbk_addr <= '0;
            hold_new  <= 1'b0;
            rdbk_dat  <= '0;
        end else begin
            state     <= state_nxt;
            rdbk_addr <= rdbk_addr_nxt;
            hold_new  <= (state == ISSUE);
            // The RAM word is only guaranteed in the first HOLD cycle; keep a copy.
            if (hold_new) rdbk_dat <= w_q;
        end
    end

    always_comb begin
        state_nxt       = state;
        rdbk_addr_nxt   = rdbk_addr;
        rdbk_sel        = 1'b0;
        mem_rdbk_valid  = 1'b0;
        mem_rdbk_last   = 1'b0;
        mem_data_output = '0;
        case (state)
            IDLE: begin
                if (mem_rdbk_req) begin
                    state_nxt     = ISSUE;
                    rdbk_addr_nxt = '0;
                end
            end
            ISSUE: begin
                rdbk_sel  = 1'b1;
                state_nxt = HOLD;
            end
            HOLD: begin
                mem_rdbk_valid  = 1'b1;
                mem_rdbk_last   = (rdbk_addr == {weightAddrLen{1'b1}});
                mem_data_output = hold_new ? w_q : rdbk_dat;
                if (mem_rdbk_ready) begin
                    if (mem_rdbk_last) begin
                        state_nxt = IDLE;
                    end else begin
                        rdbk_addr_nxt = rdbk_addr + 1'b1;
                        state_nxt     = ISSUE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- scratchpads ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            data_v_q <= 1'b0;
        end else begin
            data_v_q <= ({1'b0, core_data_rd_addr} < data_wr_cnt);
        end
    end

    generate
        if (NO_NS) begin : g_no_ns
            assign data_q = '0;
            assign w_q    = '0;
            assign meta_q = '0;
        end else begin : g_ram
            pe_ns_ram #(.W(dataLen), .AW(dataAddrLen)) u_data_ram (
                .clk   (clk),
                .reset (reset),
                .we    (data_we),
                .waddr (data_wr_cnt[dataAddrLen-1:0]),
                .wdata (mem_data_input),
                .raddr (core_data_rd_addr),
                .rdata (data_q)
            );
            pe_ns_ram #(.W(dataLen), .AW(weightAddrLen)) u_weight_ram (
                .clk   (clk),
                .reset (reset),
                .we    (w_we),
                .waddr (w_waddr),
                .wdata (w_wdata),
                .raddr (rdbk_sel ? rdbk_addr : core_weight_rd_addr),
                .rdata (w_q)
            );
            pe_ns_ram #(.W(dataLen), .AW(metaAddrLen)) u_meta_ram (
                .clk   (clk),
                .reset (reset),
                .we    (meta_we),
                .waddr (meta_wr_cnt[metaAddrLen-1:0]),
                .wdata (mem_data_input),
                .raddr (core_meta_rd_addr),
                .rdata (meta_q)
            );
        end
    endgenerate

    assign data_out   = data_q;
    assign data_out_v = NO_NS ? 1'b0 : data_v_q;
    assign weight_out = w_q;
    assign meta_out   = meta_q;

endmodule

// File: tb/tb_pe_namespace_ctrl.sv
// Randomised scoreboard bench for pe_namespace_ctrl (peId=9, lane 0).
// Latency: checks reads 1 cycle after issue and readback words on each handshake.
// Backpressure: drives random mem_rdbk_ready during readback.
module tb_pe_namespace_ctrl;
    import pe_ns_pkg::*;

    localparam int PE_ID   = 9;
    localparam int MY_LANE = (PE_ID >> (6 - 2)) % 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        eoc = 1'b0;
    logic        mem_wrt_valid = 1'b0;
    logic [1:0]  mem_lane_id = '0;
    logic [1:0]  mem_data_type = '0;
    logic [15:0] mem_data_input = '0;
    logic        mem_rdbk_req = 1'b0;
    logic        mem_rdbk_ready = 1'b0;
    logic        mem_rdbk_valid, mem_rdbk_last;
    logic [15:0] mem_data_output;
    logic [4:0]  core_data_rd_addr = '0;
    logic [15:0] data_out;
    logic        data_out_v;
    logic        core_weight_wrt = 1'b0;
    logic [4:0]  core_weight_wrt_addr = '0;
    logic [15:0] core_weight_wrt_data = '0;
    logic        core_weight_stall;
    logic [4:0]  core_weight_rd_addr = '0;
    logic [15:0] weight_out;
    logic [1:0]  core_meta_rd_addr = '0;
    logic [15:0] meta_out;
`ifdef PE_NS_OVF_CHECK_EN
    logic        ns_ovf_err;
`endif

    pe_namespace_ctrl #(.peId(PE_ID)) dut (
        .clk(clk), .reset(reset), .eoc(eoc),
        .mem_wrt_valid(mem_wrt_valid), .mem_lane_id(mem_lane_id),
        .mem_data_type(mem_data_type), .mem_data_input(mem_data_input),
        .mem_rdbk_req(mem_rdbk_req), .mem_rdbk_ready(mem_rdbk_ready),
        .mem_rdbk_valid(mem_rdbk_valid), .mem_rdbk_last(mem_rdbk_last),
        .mem_data_output(mem_data_output),
        .core_data_rd_addr(core_data_rd_addr), .data_out(data_out), .data_out_v(data_out_v),
        .core_weight_wrt(core_weight_wrt), .core_weight_wrt_addr(core_weight_wrt_addr),
        .core_weight_wrt_data(core_weight_wrt_data), .core_weight_stall(core_weight_stall),
        .core_weight_rd_addr(core_weight_rd_addr), .weight_out(weight_out),
        .core_meta_rd_addr(core_meta_rd_addr), .meta_out(meta_out)
`ifdef PE_NS_OVF_CHECK_EN
        , .ns_ovf_err(ns_ovf_err)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    logic [15:0] mdl   [4][32];
    bit          wr_ok [4][32];
    int          cnt   [4];
    int          depth [4] = '{0, 32, 32, 4};
    bit          ovf_exp = 1'b0;

    function automatic void model_wr(input int lane, input int typ, input logic [15:0] d, input bit e);
        if (e) begin
            foreach (cnt[i]) cnt[i] = 0;
        end else if (lane == MY_LANE && typ != 0) begin
            if (cnt[typ] == depth[typ]) begin
`ifdef PE_NS_OVF_CHECK_EN
                ovf_exp = 1'b1;
`else
                mdl[typ][0] = d;
                cnt[typ]    = 1;
`endif
            end else begin
                mdl[typ][cnt[typ]]   = d;
                wr_ok[typ][cnt[typ]] = 1'b1;
                cnt[typ]++;
            end
        end
    endfunction

    typedef struct { int kind; logic [15:0] d; bit v; } rd_t;
    typedef struct { logic [15:0] d; bit last; } rb_t;
    rd_t rd_q[$];
    rb_t rb_q[$];
    bit  rd_issue = 1'b0;
    bit  rb_ready_en = 1'b0;

    // ---------------- driver helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
        mem_wrt_valid   = 1'b0;
        eoc             = 1'b0;
        core_weight_wrt = 1'b0;
        mem_rdbk_req    = 1'b0;
        rd_issue        = 1'b0;
    endtask

    task automatic mem_wr(input int lane, input int typ, input logic [15:0] d, input bit e);
        mem_wrt_valid  = 1'b1;
        mem_lane_id    = 2'(lane);
        mem_data_type  = 2'(typ);
        mem_data_input = d;
        eoc            = e;
        model_wr(lane, typ, d, e);
        step();
    endtask

    task automatic do_eoc();
        eoc = 1'b1;
        model_wr(0, 0, '0, 1'b1);
        step();
    endtask

    task automatic rd(input int kind, input int addr);
        rd_t e;
        e.kind = kind;
        case (kind)
            0: begin core_data_rd_addr = 5'(addr); e.d = mdl[1][addr]; e.v = (addr < cnt[1]); end
            1: begin core_weight_rd_addr = 5'(addr); e.d = mdl[2][addr]; e.v = 1'b1; end
            default: begin core_meta_rd_addr = 2'(addr); e.d = mdl[3][addr]; e.v = 1'b1; end
        endcase
        rd_q.push_back(e);
        rd_issue = 1'b1;
        step();
    endtask

    // ---------------- monitor ----------------
    initial begin
        bit  pend;
        rd_t e;
        rb_t r;
        forever begin
            @(posedge clk);
            pend = rd_issue;
            @(negedge clk);
            if (pend) begin
                if (rd_q.size() == 0) check("rd_q_underflow", 32'd1, 32'd0);
                else begin
                    e = rd_q.pop_front();
                    case (e.kind)
                        0: begin
                            check("data_out_v", 32'(data_out_v), 32'(e.v));
                            if (e.v) check("data_out", 32'(data_out), 32'(e.d));
                        end
                        1: check("weight_out", 32'(weight_out), 32'(e.d));
                        default: check("meta_out", 32'(meta_out), 32'(e.d));
                    endcase
                end
            end
            if (mem_rdbk_valid && mem_rdbk_ready) begin
                if (rb_q.size() == 0) check("rdbk_extra_word", 32'd1, 32'd0);
                else begin
                    r = rb_q.pop_front();
                    check("rdbk_data", 32'(mem_data_output), 32'(r.d));
                    check("rdbk_last", 32'(mem_rdbk_last), 32'(r.last));
                end
            end
        end
    end

    // Random readback backpressure.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            mem_rdbk_ready = rb_ready_en ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] w0;
        foreach (cnt[i]) cnt[i] = 0;
        foreach (mdl[i, j]) begin mdl[i][j] = '0; wr_ok[i][j] = 1'b0; end

        repeat (3) step();
        check("rst_data_out",   32'(data_out), 32'd0);
        check("rst_data_out_v", 32'(data_out_v), 32'd0);
        check("rst_weight_out", 32'(weight_out), 32'd0);
        check("rst_meta_out",   32'(meta_out), 32'd0);
        check("rst_rdbk_valid", 32'(mem_rdbk_valid), 32'd0);
        check("rst_rdbk_last",  32'(mem_rdbk_last), 32'd0);
        check("rst_rdbk_data",  32'(mem_data_output), 32'd0);
        check("rst_stall",      32'(core_weight_stall), 32'd0);
`ifdef PE_NS_OVF_CHECK_EN
        check("rst_ovf_err",    32'(ns_ovf_err), 32'd0);
`endif
        reset = 1'b0;
        step();

        // Lane filtering: lane 1 ignored, lane 0 lands at addr 0.
        mem_wr(1, 1, 16'h5555, 1'b0);
        rd(0, 0);
        mem_wr(MY_LANE, 1, 16'h1234, 1'b0);
        rd(0, 0);

        // eoc beats a simultaneous hit.
        mem_wr(MY_LANE, 1, 16'h7777, 1'b1);
        rd(0, 0);

        // Data readiness.
        mem_wr(MY_LANE, 1, 16'h1111, 1'b0);
        mem_wr(MY_LANE, 1, 16'h2222, 1'b0);
        mem_wr(MY_LANE, 1, 16'h3333, 1'b0);
        rd(0, 2);
        rd(0, 3);

        // Random traffic across lanes and namespaces.
        do_eoc();
        for (int i = 0; i < 60; i++) begin
            mem_wr($urandom_range(0, 3), $urandom_range(0, 3), 16'($urandom),
                   ($urandom_range(0, 15) == 0));
        end
        for (int a = 0; a < 4; a++) if (wr_ok[3][a]) rd(2, a);
        for (int i = 0; i < 12; i++) rd(0, $urandom_range(0, 31));
        for (int a = 0; a < 32; a++) if (wr_ok[2][a]) rd(1, a);

        // Weight collisions.
        do_eoc();
        for (int i = 0; i < 4; i++) mem_wr(MY_LANE, 2, 16'($urandom), 1'b0);
        mem_wrt_valid = 1'b1; mem_lane_id = 2'(MY_LANE); mem_data_type = 2'(NS_WEIGHT);
        mem_data_input = 16'hAAAA;
        core_weight_wrt = 1'b1; core_weight_wrt_addr = 5'd20; core_weight_wrt_data = 16'hBBBB;
        #1;
        check("stall_first_collision", 32'(core_weight_stall), 32'd0);
        model_wr(MY_LANE, 2, 16'hAAAA, 1'b0);
        mdl[2][20] = 16'hBBBB; wr_ok[2][20] = 1'b1;
        step();
        w0 = 16'($urandom);
        mem_wrt_valid = 1'b1; mem_lane_id = 2'(MY_LANE); mem_data_type = 2'(NS_WEIGHT);
        mem_data_input = w0;
        core_weight_wrt = 1'b1; core_weight_wrt_addr = 5'd21; core_weight_wrt_data = 16'hCCCC;
        #1;
        check("stall_second_collision", 32'(core_weight_stall), 32'd1);
        model_wr(MY_LANE, 2, w0, 1'b0);
        step();
        core_weight_wrt = 1'b1; core_weight_wrt_addr = 5'd21; core_weight_wrt_data = 16'hCCCC;
        #1;
        check("stall_released", 32'(core_weight_stall), 32'd0);
        mdl[2][21] = 16'hCCCC; wr_ok[2][21] = 1'b1;
        step();
        repeat (3) step();
        rd(1, 4); rd(1, 5); rd(1, 20); rd(1, 21); rd(1, 0);

        // Readback of a full weight namespace under random backpressure.
        do_eoc();
        for (int i = 0; i < 32; i++) mem_wr(MY_LANE, 2, 16'($urandom), 1'b0);
        repeat (2) step();
        for (int a = 0; a < 32; a++) begin
            rb_t r;
            r.d = mdl[2][a];
            r.last = (a == 31);
            rb_q.push_back(r);
        end
        rb_ready_en = 1'b1;
        mem_rdbk_req = 1'b1;
        step();
        check("stall_during_rdbk", 32'(core_weight_stall), 32'd1);
        for (int i = 0; i < 1000 && rb_q.size() != 0; i++) begin
            if (i == 5) mem_rdbk_req = 1'b1;
            if (i == 9) begin eoc = 1'b1; model_wr(0, 0, '0, 1'b1); end
            step();
        end
        check("rdbk_words_left", 32'(rb_q.size()), 32'd0);
        rb_ready_en = 1'b0;
        repeat (2) step();
        check("rdbk_idle_valid", 32'(mem_rdbk_valid), 32'd0);
        check("rdbk_idle_stall", 32'(core_weight_stall), 32'd0);

        // Overflow: 33 data writes into a 32-entry namespace.
        do_eoc();
`ifdef PE_NS_OVF_CHECK_EN
        check("ovf_err_before", 32'(ns_ovf_err), 32'd0);
`endif
        for (int i = 0; i < 33; i++) mem_wr(MY_LANE, 1, 16'($urandom), 1'b0);
        rd(0, 0);
        rd(0, 31);
        rd(0, 1);
`ifdef PE_NS_OVF_CHECK_EN
        check("ovf_err_after", 32'(ns_ovf_err), 32'(ovf_exp));
`endif
        repeat (3) step();
        check("rd_q_drained", 32'(rd_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
